tlp_dma_send: RTL and testbench

Multi-channel FPGA->CPU DMA write engine for the PCIe TLP transceiver. Arbitrates round-robin between NUM_CHAN f2c pipes, segments each chunk into memory-write TLPs of parametrised size into that channel's CPU circular buffer, then DMAs a per-channel metrics record. Feeds the 64-bit Avalon-ST tx stream through the existing tx arbiter. Generalises the single-channel fixed-size f2c path with per-channel buffers, programmable geometry, mid-packet source stalls and graceful disable.

---
 rtl/tlp_dma_send.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_tlp_dma_send.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_dma_send.sv
// tlp_dma_send: multi-channel FPGA->CPU DMA write engine.
//
// Picks an f2c channel round-robin and streams one chunk from it as a run of
// memory-write TLPs into that channel's circular buffer in CPU memory. After
// the chunk it writes a 4-DW metrics record (channel, write pointer, chunk count).
// Output is a 64-bit Avalon-ST style tx stream. A beat is valid only when the
// sink is ready, so every valid beat transfers.
//
// Ports:
//   pcieClk_in, pcieRstN_in     clock, synchronous active-low reset
//   cfgBusDev_in                requester ID placed in every header
//   cfg{Chan,Reg,Data,Valid}_in per-channel config writes (BASE/RDPTR/ENABLE/MTR_BASE)
//   f2cData_in/f2cValid_in      per-channel payload QWs
//   f2cReady_out                per-channel read commit, one per payload beat
//   f2cReset_out                one-cycle flush pulse when a disable takes effect
//   txData_out/txValid_out/txSOP_out/txEOP_out, txReady_in   tx stream
//   busy_out                    high while a chunk or metrics record is in flight
module tlp_dma_send #(
    parameter int unsigned NUM_CHAN    = 2,
    parameter int unsigned TLP_NBITS   = 7,
    parameter int unsigned CHUNK_NBITS = 12,
    parameter int unsigned PTR_NBITS   = 4,
    localparam int unsigned CI         = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic                    pcieClk_in,
    input  logic                    pcieRstN_in,
    input  logic [15:0]             cfgBusDev_in,
    input  logic [CI-1:0]           cfgChan_in,
    input  logic [1:0]              cfgReg_in,
    input  logic [31:0]             cfgData_in,
    input  logic                    cfgValid_in,
    input  logic [64*NUM_CHAN-1:0]  f2cData_in,
    input  logic [NUM_CHAN-1:0]     f2cValid_in,
    output logic [NUM_CHAN-1:0]     f2cReady_out,
    output logic [NUM_CHAN-1:0]     f2cReset_out,
    output logic [63:0]             txData_out,
    output logic                    txValid_out,
    input  logic                    txReady_in,
    output logic                    txSOP_out,
    output logic                    txEOP_out,
    output logic                    busy_out
);

    localparam int unsigned     SEG_W    = (CHUNK_NBITS > TLP_NBITS) ? CHUNK_NBITS - TLP_NBITS : 1;
    localparam int unsigned     QW_W     = TLP_NBITS - 3;
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'((1 << (CHUNK_NBITS - TLP_NBITS)) - 1);
    localparam logic [9:0]      TLP_DWS  = 10'(1 << (TLP_NBITS - 2));
    localparam logic [9:0]      MTR_DWS  = 10'd4;

    typedef enum logic [2:0] {
        StIdle, StHdr0, StHdr1, StData, StMtr0, StMtr1, StMtr2, StMtr3
    } state_e;

    // First QW of a 4-DW MWr header: DW0 (fmt/type/length) low, DW1 (req ID, tag, BEs) high.
    function automatic logic [63:0] gen_dma_write0(input logic [15:0] req_id,
                                                   input logic [9:0]  dw_count);
        return {req_id, 8'h00, 8'hFF, 3'b011, 5'b00000, 14'd0, dw_count};
    endfunction

    // Second QW: 64-bit byte address, DW2 (upper half) first on the wire.
    function automatic logic [63:0] gen_dma_write1(input logic [63:0] dw_addr);
        logic [63:0] byte_addr;
        byte_addr = {dw_addr[61:0], 2'b00};
        return {byte_addr[31:0], byte_addr[63:32]};
    endfunction

    state_e               state_q, state_d;
    logic [CI-1:0]        gnt_q, gnt_d;
    logic [CI-1:0]        last_q, last_d;
    logic [63:0]          addr_q, addr_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic [QW_W-1:0]      qw_q, qw_d;

    logic [31:0]          base_q [NUM_CHAN];
    logic [31:0]          base_d [NUM_CHAN];
    logic [31:0]          mtr_q  [NUM_CHAN];
    logic [31:0]          mtr_d  [NUM_CHAN];
    logic [PTR_NBITS-1:0] wr_q   [NUM_CHAN];
    logic [PTR_NBITS-1:0] wr_d   [NUM_CHAN];
    logic [PTR_NBITS-1:0] rd_q   [NUM_CHAN];
    logic [PTR_NBITS-1:0] rd_d   [NUM_CHAN];
    logic [31:0]          cnt_q  [NUM_CHAN];
    logic [31:0]          cnt_d  [NUM_CHAN];
    logic [NUM_CHAN-1:0]  en_q, en_d;
    logic [NUM_CHAN-1:0]  dis_q, dis_d;

    logic [63:0]          chan_data [NUM_CHAN];
    logic [NUM_CHAN-1:0]  elig;
    logic                 found;
    logic [CI-1:0]        pick;
    logic                 pkt_end;
    logic [NUM_CHAN-1:0]  apply;

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        assign chan_data[c] = f2cData_in[64*c +: 64];
        assign elig[c] = en_q[c] && !dis_q[c] && f2cValid_in[c] &&
                         (PTR_NBITS'(wr_q[c] + 1'b1) != rd_q[c]);
    end

    // Round-robin search starting at the channel after the last grant.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= int'(NUM_CHAN); i++) begin
            if (!found && elig[CI'((int'(last_q) + i) % int'(NUM_CHAN))]) begin
                found = 1'b1;
                pick  = CI'((int'(last_q) + i) % int'(NUM_CHAN));
            end
        end
    end

    assign busy_out = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        seg_d   = seg_q;
        qw_d    = qw_q;
        base_d  = base_q;
        mtr_d   = mtr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        dis_d   = dis_q;
        txValid_out  = 1'b0;
        txSOP_out    = 1'b0;
        txEOP_out    = 1'b0;
        txData_out   = '0;
        f2cReady_out = '0;
        f2cReset_out = '0;
        pkt_end      = 1'b0;
        apply        = '0;

        unique case (state_q)
            StIdle: begin
                // HDR0 goes out in the arbitration cycle itself.
                if (found && txReady_in) begin
                    txValid_out = 1'b1;
                    txSOP_out   = 1'b1;
                    txData_out  = gen_dma_write0(cfgBusDev_in, TLP_DWS);
                    gnt_d       = pick;
                    last_d      = pick;
                    addr_d      = {31'd0, base_q[pick], 1'b0} +
                                  (64'(wr_q[pick]) << (CHUNK_NBITS - 2));
                    seg_d       = '0;
                    qw_d        = '0;
                    state_d     = StHdr1;
                end
            end
            StHdr0: begin
                if (txReady_in) begin
                    txValid_out = 1'b1;
                    txSOP_out   = 1'b1;
                    txData_out  = gen_dma_write0(cfgBusDev_in, TLP_DWS);
                    state_d     = StHdr1;
                end
            end
            StHdr1: begin
                if (txReady_in) begin
                    txValid_out = 1'b1;
                    txData_out  = gen_dma_write1(addr_q);
                    state_d     = StData;
                end
            end
            StData: begin
                if (txReady_in && f2cValid_in[gnt_q]) begin
                    txValid_out          = 1'b1;
                    txData_out           = chan_data[gnt_q];
                    f2cReady_out[gnt_q]  = 1'b1;
                    qw_d                 = qw_q + 1'b1;
                    if (qw_q == '1) begin
                        txEOP_out = 1'b1;
                        pkt_end   = 1'b1;
                        if (dis_q[gnt_q]) begin
                            // Pending disable: drop the rest of the chunk and its metrics.
                            state_d = StIdle;
                        end else if (seg_q == LAST_SEG) begin
                            wr_d[gnt_q]  = wr_q[gnt_q] + 1'b1;
                            cnt_d[gnt_q] = cnt_q[gnt_q] + 32'd1;
                            state_d      = StMtr0;
                        end else begin
                            addr_d  = addr_q + 64'(TLP_DWS);
                            seg_d   = seg_q + 1'b1;
                            state_d = StHdr0;
                        end
                    end
                end
            end
            StMtr0: begin
                if (txReady_in) begin
                    txValid_out = 1'b1;
                    txSOP_out   = 1'b1;
                    txData_out  = gen_dma_write0(cfgBusDev_in, MTR_DWS);
                    state_d     = StMtr1;
                end
            end
            StMtr1: begin
                if (txReady_in) begin
                    txValid_out = 1'b1;
                    txData_out  = gen_dma_write1({31'd0, mtr_q[gnt_q], 1'b0});
                    state_d     = StMtr2;
                end
            end
            StMtr2: begin
                if (txReady_in) begin
                    txValid_out = 1'b1;
                    txData_out  = {32'(gnt_q), 32'(wr_q[gnt_q])};
                    state_d     = StMtr3;
                end
            end
            StMtr3: begin
                if (txReady_in) begin
                    txValid_out = 1'b1;
                    txEOP_out   = 1'b1;
                    txData_out  = {32'd0, cnt_q[gnt_q]};
                    pkt_end     = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A disable lands immediately on an idle channel, or at a packet boundary
        // on the granted one so no packet is ever cut short.
        for (int c = 0; c < int'(NUM_CHAN); c++) begin
            apply[c] = dis_q[c] && (!(busy_out && gnt_q == CI'(c)) || pkt_end);
            if (apply[c]) begin
                dis_d[c]        = 1'b0;
                f2cReset_out[c] = 1'b1;
            end
        end

        if (cfgValid_in && (int'(cfgChan_in) < int'(NUM_CHAN))) begin
            case (cfgReg_in)
                2'd0: base_d[cfgChan_in] = cfgData_in;
                2'd1: rd_d[cfgChan_in]   = cfgData_in[PTR_NBITS-1:0];
                2'd2: begin
                    if (cfgData_in[0]) begin
                        en_d[cfgChan_in] = 1'b1;
                    end else begin
                        en_d[cfgChan_in]  = 1'b0;
                        dis_d[cfgChan_in] = 1'b1;
                    end
                end
                default: mtr_d[cfgChan_in] = cfgData_in;
            endcase
        end

        // Flush overrides both the pointer increment and any RDPTR write.
        for (int c = 0; c < int'(NUM_CHAN); c++) begin
            if (apply[c]) begin
                wr_d[c]  = '0;
                rd_d[c]  = '0;
                cnt_d[c] = '0;
            end
        end
    end

    always_ff @(posedge pcieClk_in) begin
        if (!pcieRstN_in) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            last_q  <= CI'(NUM_CHAN - 1);
            addr_q  <= '0;
            seg_q   <= '0;
            qw_q    <= '0;
            base_q  <= '{default: '0};
            mtr_q   <= '{default: '0};
            wr_q    <= '{default: '0};
            rd_q    <= '{default: '0};
            cnt_q   <= '{default: '0};
            en_q    <= '0;
            dis_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            seg_q   <= seg_d;
            qw_q    <= qw_d;
            base_q  <= base_d;
            mtr_q   <= mtr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            dis_q   <= dis_d;
        end
    end

endmodule

// File: tb/tb_tlp_dma_send.sv
// Directed bench for tlp_dma_send with 2 channels, 128-byte TLPs, 512-byte
// chunks and a 4-entry ring. Beats are captured on the falling edge; each
// test then checks the captured stream against hand-computed headers,
// addresses and metrics.
module tb_tlp_dma_send;

    localparam logic [15:0] BUS_DEV = 16'h0A01;
    localparam logic [63:0] HDR_TLP = 64'h0A01_00FF_6000_0020;
    localparam logic [63:0] HDR_MTR = 64'h0A01_00FF_6000_0004;

    logic         clk = 1'b0;
    logic         rstn;
    logic [15:0]  cfg_bus_dev;
    logic [0:0]   cfg_chan;
    logic [1:0]   cfg_reg;
    logic [31:0]  cfg_data;
    logic         cfg_valid;
    logic [127:0] f2c_data;
    logic [1:0]   f2c_valid;
    logic [1:0]   f2c_ready;
    logic [1:0]   f2c_reset;
    logic [63:0]  tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_sop;
    logic         tx_eop;
    logic         busy;

    always #5 clk = ~clk;

    tlp_dma_send #(
        .NUM_CHAN    (2),
        .TLP_NBITS   (7),
        .CHUNK_NBITS (9),
        .PTR_NBITS   (2)
    ) dut (
        .pcieClk_in   (clk),
        .pcieRstN_in  (rstn),
        .cfgBusDev_in (cfg_bus_dev),
        .cfgChan_in   (cfg_chan),
        .cfgReg_in    (cfg_reg),
        .cfgData_in   (cfg_data),
        .cfgValid_in  (cfg_valid),
        .f2cData_in   (f2c_data),
        .f2cValid_in  (f2c_valid),
        .f2cReady_out (f2c_ready),
        .f2cReset_out (f2c_reset),
        .txData_out   (tx_data),
        .txValid_out  (tx_valid),
        .txReady_in   (tx_ready),
        .txSOP_out    (tx_sop),
        .txEOP_out    (tx_eop),
        .busy_out     (busy)
    );

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [63:0] d;
    } beat_t;

    beat_t       beats[$];
    logic [31:0] seq [2];
    int          stall_cnt = 0;
    int          rst_cnt [2];
    logic        prev_eop = 1'b0;
    logic        busy_after_eop = 1'b1;
    int          n_checks = 0;
    int          n_pass = 0;

    // Source payload: channel number in the top byte, running sequence number below.
    assign f2c_data = {8'd1, 24'd0, seq[1], 8'd0, 24'd0, seq[0]};

    initial begin
        seq[0] = 0;
        seq[1] = 0;
        rst_cnt[0] = 0;
        rst_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (tx_valid === 1'b1) beats.push_back('{sop: tx_sop, eop: tx_eop, d: tx_data});
            if (busy === 1'b1 && tx_valid !== 1'b1) stall_cnt++;
            for (int c = 0; c < 2; c++) begin
                if (f2c_reset[c] === 1'b1) rst_cnt[c]++;
                if (f2c_ready[c] === 1'b1) seq[c] = seq[c] + 1;
            end
            if (prev_eop) busy_after_eop = busy;
            prev_eop = (tx_valid === 1'b1) && (tx_eop === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [63:0] exp_hdr1(input logic [63:0] dw);
        logic [63:0] b;
        b = dw << 2;
        return {b[31:0], b[63:32]};
    endfunction

    task automatic cfg_wr(input int ch, input int r, input logic [31:0] d);
        @(posedge clk); #1;
        cfg_chan  = 1'(ch);
        cfg_reg   = 2'(r);
        cfg_data  = d;
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Waits for 20 consecutive idle cycles; an expired budget counts as a failure.
    task automatic wait_quiet(input string tag);
        int idle = 0;
        int n = 0;
        while (idle < 20 && n < 3000) begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1 && tx_valid !== 1'b1) idle++;
            else idle = 0;
        end
        check(tag, 64'(n >= 3000), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_beats(input int n, input string tag);
        int k = 0;
        while (beats.size() < n && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, 64'(beats.size() >= n), 64'd1);
    endtask

    // One full chunk: 4 TLPs of 18 beats then 4 metrics beats.
    task automatic check_chunk(input int s, input int ch, input logic [63:0] dw,
                               input int wp, input int cnt, input logic [63:0] mtr_dw);
        int h;
        check("chunk_len", 64'(beats.size() >= s + 76), 64'd1);
        if (beats.size() < s + 76) return;
        for (int t = 0; t < 4; t++) begin
            h = s + 18 * t;
            check("hdr0", beats[h].d, HDR_TLP);
            check("sop", 64'(beats[h].sop), 64'd1);
            check("hdr1_addr", beats[h + 1].d, exp_hdr1(dw + 64'(32 * t)));
            check("data_chan", 64'(beats[h + 2].d[63:56]), 64'(ch));
            check("data_eop", {63'd0, beats[h + 17].eop} | {62'd0, beats[h + 16].eop, 1'b0},
                  64'd1);
        end
        check("mtr_hdr0", beats[s + 72].d, HDR_MTR);
        check("mtr_sop", 64'(beats[s + 72].sop), 64'd1);
        check("mtr_addr", beats[s + 73].d, exp_hdr1(mtr_dw));
        check("mtr_ptr", beats[s + 74].d, {32'(ch), 32'(wp)});
        check("mtr_cnt", beats[s + 75].d, 64'(cnt));
        check("mtr_eop", 64'(beats[s + 75].eop), 64'd1);
    endtask

    initial begin
        int b0;
        int b1;
        int s0;
        int r0;
        int errs;
        int nsop;
        int neop;
        logic [31:0] prev;

        rstn        = 1'b0;
        cfg_bus_dev = BUS_DEV;
        cfg_chan    = '0;
        cfg_reg     = '0;
        cfg_data    = '0;
        cfg_valid   = 1'b0;
        f2c_valid   = 2'b00;
        tx_ready    = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", tx_data, 64'd0);
        check("rst_ready", 64'(f2c_ready), 64'd0);
        check("rst_flush", 64'(f2c_reset), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // ch0 streams until its ring is full (rdPtr=0 -> 3 chunks).
        s0 = stall_cnt;
        cfg_wr(0, 0, 32'h1000);
        cfg_wr(0, 3, 32'h2000);
        cfg_wr(0, 1, 32'h0);
        f2c_valid = 2'b01;
        cfg_wr(0, 2, 32'h1);
        wait_quiet("t1_quiet");
        check("t1_beats", 64'(beats.size()), 64'd228);
        check_chunk(0, 0, 64'h2000, 1, 1, 64'h4000);
        check_chunk(76, 0, 64'h2080, 2, 2, 64'h4000);
        check_chunk(152, 0, 64'h2100, 3, 3, 64'h4000);
        errs = 0;
        for (int t = 0; t < 4; t++)
            for (int k = 0; k < 16; k++)
                if (beats[18 * t + 2 + k].d[31:0] != 32'(16 * t + k)) errs++;
        check("t1_seq", 64'(errs), 64'd0);
        check("t1_no_gaps", 64'(stall_cnt - s0), 64'd0);

        // RDPTR=1 frees one slot: one more chunk at wrPtr 3, then wrap to 0.
        // Source stalls for 5 cycles mid-payload.
        b0 = beats.size();
        s0 = stall_cnt;
        cfg_wr(0, 1, 32'h1);
        wait_beats(b0 + 10, "t4_start");
        f2c_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        f2c_valid = 2'b01;
        wait_quiet("t4_quiet");
        check("t4_beats", 64'(beats.size() - b0), 64'd76);
        check_chunk(b0, 0, 64'h2180, 0, 4, 64'h4000);
        check("t4_stall", 64'(stall_cnt - s0), 64'd5);
        nsop = 0;
        neop = 0;
        errs = 0;
        for (int i = b0; i < beats.size(); i++) begin
            if (beats[i].sop) nsop++;
            if (beats[i].eop) neop++;
        end
        prev = beats[b0 + 2].d[31:0] - 32'd1;
        for (int t = 0; t < 4; t++)
            for (int k = 0; k < 16; k++) begin
                if (beats[b0 + 18 * t + 2 + k].d[31:0] != prev + 32'd1) errs++;
                prev = beats[b0 + 18 * t + 2 + k].d[31:0];
            end
        check("t4_sops", 64'(nsop), 64'd5);
        check("t4_eops", 64'(neop), 64'd5);
        check("t4_seq", 64'(errs), 64'd0);

        // Disable ch0 during its 2nd TLP.
        b0 = beats.size();
        r0 = rst_cnt[0];
        cfg_wr(0, 1, 32'h2);
        wait_beats(b0 + 23, "t5_start");
        cfg_wr(0, 2, 32'h0);
        wait_quiet("t5_quiet");
        check("t5_beats", 64'(beats.size() - b0), 64'd36);
        check("t5_hdr1", beats[b0 + 19].d, exp_hdr1(64'h2020));
        check("t5_eop", 64'(beats[b0 + 35].eop), 64'd1);
        check("t5_flush", 64'(rst_cnt[0] - r0), 64'd1);
        check("t5_busy_after", 64'(busy_after_eop), 64'd0);

        // Both channels valid: chunks alternate 1,0,1,0,1,0 (last grant was ch0).
        f2c_valid = 2'b00;
        cfg_wr(1, 0, 32'h3000);
        cfg_wr(1, 3, 32'h3800);
        cfg_wr(0, 2, 32'h1);
        cfg_wr(1, 2, 32'h1);
        b0 = beats.size();
        s0 = stall_cnt;
        f2c_valid = 2'b11;
        wait_quiet("t2_quiet");
        check("t2_beats", 64'(beats.size() - b0), 64'd456);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                check_chunk(b0 + 76 * i, 1, 64'h6000 + 64'(128 * (i / 2)), i / 2 + 1, i / 2 + 1,
                            64'h7000);
            else
                check_chunk(b0 + 76 * i, 0, 64'h2000 + 64'(128 * (i / 2)), i / 2 + 1, i / 2 + 1,
                            64'h4000);
        end
        check("t2_no_gaps", 64'(stall_cnt - s0), 64'd0);

        // Reset while the metrics record is half sent.
        b0 = beats.size();
        cfg_wr(1, 1, 32'h1);
        wait_beats(b0 + 74, "t6_start");
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_valid", 64'(tx_valid), 64'd0);
        check("t6_data", tx_data, 64'd0);
        check("t6_sop_eop", {62'd0, tx_sop, tx_eop}, 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_ready", 64'(f2c_ready), 64'd0);
        check("t6_flush", 64'(f2c_reset), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        check("t6_beats", 64'(beats.size() - b0), 64'd75);
        check("t6_no_eop", 64'(beats[b0 + 74].eop), 64'd0);
        b1 = beats.size();
        wait_quiet("t6_quiet");
        check("t6_disabled", 64'(beats.size() - b1), 64'd0);
        cfg_wr(1, 2, 32'h1);
        wait_quiet("t6_quiet2");
        check("t6_resume", 64'(beats.size() - b1), 64'd228);
        check_chunk(b1, 1, 64'h0, 1, 1, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
